// File: rtl/avl_uart_slave.sv
// avl_uart_slave: Avalon-MM pipelined slave UART (8N1) with TX/RX byte FIFOs.
// Ports: clk, reset_n, avs_* slave bus, uart_txd/uart_rxd pins; irq only when
//   AVL_UART_IRQ_EN is defined (adds IRQ_EN register at 0x0C).
module avl_uart_slave #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [3:0]  avs_byteenable,
  input  logic [31:0] avs_writedata,
  input  logic        avs_burstcount,
  input  logic        avs_debugaccess,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        uart_txd,
  input  logic        uart_rxd
`ifdef AVL_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;

  logic unused;
  assign unused = ^{avs_address[1:0], avs_writedata[31:16],
                    avs_byteenable[3:2], avs_burstcount, avs_debugaccess};

  // bus decode
  logic sel_data, sel_stat, sel_div, sel_irq;
  logic wr_acc, rd_acc;
  assign sel_data = avs_address[4:2] == 3'd0;
  assign sel_stat = avs_address[4:2] == 3'd1;
  assign sel_div  = avs_address[4:2] == 3'd2;
  assign sel_irq  = avs_address[4:2] == 3'd3;

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign avs_waitrequest = avs_write & sel_data & tx_full;
  assign wr_acc = avs_write & ~avs_waitrequest;
  // a write in the same cycle drops the read
  assign rd_acc = avs_read & ~avs_write;

  // FIFOs
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic        tx_push, tx_pop, rx_push, rx_pop;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                    (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                    (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  assign tx_push = wr_acc & sel_data & avs_byteenable[0];
  assign rx_pop  = rd_acc & sel_data & ~rx_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  logic [7:0] rx_sh_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= avs_writedata[7:0];
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  // control registers
  logic [15:0] div_q, div_d, div_wr;
  logic        ovr_q, ferr_q, ovr_set, ferr_set;
  logic        clr_ovr, clr_ferr;
  logic        tx_busy;

  assign div_wr = {avs_byteenable[1] ? avs_writedata[15:8] : div_q[15:8],
                   avs_byteenable[0] ? avs_writedata[7:0]  : div_q[7:0]};
  assign div_d  = (div_wr < 16'd4) ? 16'd4 : div_wr;

  assign clr_ovr  = wr_acc & sel_stat & avs_byteenable[0] & avs_writedata[4];
  assign clr_ferr = wr_acc & sel_stat & avs_byteenable[0] & avs_writedata[5];

`ifdef AVL_UART_IRQ_EN
  logic [2:0] irq_en_q;
  logic       irq_q;
  assign irq = irq_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= 16'(DEFAULT_DIV);
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
`ifdef AVL_UART_IRQ_EN
      irq_en_q <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      if (wr_acc && sel_div) div_q <= div_d;
      ovr_q  <= ovr_set  | (ovr_q  & ~clr_ovr);
      ferr_q <= ferr_set | (ferr_q & ~clr_ferr);
`ifdef AVL_UART_IRQ_EN
      if (wr_acc && sel_irq && avs_byteenable[0])
        irq_en_q <= avs_writedata[2:0];
      irq_q <= |(irq_en_q & {ovr_q | ferr_q, tx_empty, ~rx_empty});
`endif
    end
  end

  // read path
  logic [31:0] rd_mux, status;
  logic [7:0]  rx_byte;
  assign rx_byte = rx_empty ? 8'h00 : rx_mem[rx_rp_q[AW-1:0]];
  assign status  = {25'b0, tx_busy, ferr_q, ovr_q,
                    rx_full, ~rx_empty, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_data: rd_mux = {23'b0, ~rx_empty, rx_byte};
      sel_stat: rd_mux = status;
      sel_div:  rd_mux = {16'b0, div_q};
`ifdef AVL_UART_IRQ_EN
      sel_irq:  rd_mux = {29'b0, irq_en_q};
`endif
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_acc;
      if (rd_acc) avs_readdata <= rd_mux;
    end
  end

  // TX engine
  st_e         tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        txd_q, txd_d, tx_tick;

  assign tx_tick  = tx_cnt_q == 16'd0;
  assign uart_txd = txd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_sh_q  <= '0;
      tx_idx_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_sh_q  <= tx_sh_d;
      tx_idx_q <= tx_idx_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      S_IDLE:
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem[tx_rp_q[AW-1:0]];
          tx_cnt_d = div_q - 16'd1;
          tx_st_d  = S_START;
        end
      S_START:
        if (tx_tick) begin
          tx_cnt_d = div_q - 16'd1;
          tx_idx_d = '0;
          tx_st_d  = S_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      S_DATA:
        if (tx_tick) begin
          tx_cnt_d = div_q - 16'd1;
          tx_sh_d  = tx_sh_q >> 1;
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_st_d = S_STOP;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      S_STOP:
        if (tx_tick) begin
          // chain straight into the next frame when data is waiting
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_mem[tx_rp_q[AW-1:0]];
            tx_cnt_d = div_q - 16'd1;
            tx_st_d  = S_START;
          end else tx_st_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
    endcase
  end

  always_comb begin
    txd_d   = 1'b1;
    tx_busy = tx_st_q != S_IDLE;
    unique case (tx_st_q)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_q[0];
      S_STOP:  txd_d = 1'b1;
    endcase
  end

  // RX engine
  st_e         rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_sh_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_tick, rx_fall, rx_ok, rx_bad;

  assign rx_tick = rx_cnt_q == 16'd0;
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_sh_q   <= '0;
      rx_idx_q  <= '0;
    end else begin
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_idx_q  <= rx_idx_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_sh_d  = rx_sh_q;
    rx_idx_d = rx_idx_q;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    unique case (rx_st_q)
      S_IDLE:
        if (rx_fall) begin
          rx_cnt_d = {1'b0, div_q[15:1]};
          rx_st_d  = S_START;
        end
      S_START:
        if (rx_tick) begin
          rx_cnt_d = div_q - 16'd1;
          rx_idx_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      S_DATA:
        if (rx_tick) begin
          rx_cnt_d = div_q - 16'd1;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_st_d = S_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      S_STOP:
        if (rx_tick) begin
          rx_ok   = rx_s2_q;
          rx_bad  = ~rx_s2_q;
          rx_st_d = S_IDLE;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
    endcase
  end

  // a pop in the same cycle frees the slot of a full FIFO
  always_comb begin
    rx_push  = rx_ok & (~rx_full | rx_pop);
    ovr_set  = rx_ok & rx_full & ~rx_pop;
    ferr_set = rx_bad;
  end

endmodule
